// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with a valid/ready handshake on both sides.
// MODE=0 picks the highest set request; MODE=1 rotates priority with a pointer.
module prio_encoder_rr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MODE  = 0,
    localparam int unsigned IW   = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IW-1:0]    idx,
    output logic             any,
    output logic             multi,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_idx;
    logic          r_any;
    logic          r_multi;
    logic          r_out_valid;

    logic          w_xfer_in;
    logic          w_any;
    logic          w_multi;
    logic [IW-1:0] w_fix_idx;
    logic [IW-1:0] w_rr_hi_idx;
    logic          w_rr_hi_found;
    logic [IW-1:0] w_rr_lo_idx;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_ptr_nxt;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_xfer_in = in_valid && in_ready;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_any   = |req;
    assign w_multi = (req & (req - WIDTH'(1))) != '0;

    // Fixed priority: the last set bit seen in an ascending scan is the highest.
    always_comb begin
        w_fix_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req[i]) begin
                w_fix_idx = IW'(i);
            end
        end
    end

    // Round robin: lowest set bit at or above ptr, else wrap to lowest set bit overall.
    always_comb begin
        w_rr_hi_idx   = '0;
        w_rr_hi_found = 1'b0;
        w_rr_lo_idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_rr_lo_idx = IW'(i);
                if (IW'(i) >= r_ptr) begin
                    w_rr_hi_idx   = IW'(i);
                    w_rr_hi_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_idx = '0;
        if (w_any) begin
            if (MODE == 1) begin
                w_idx = w_rr_hi_found ? w_rr_hi_idx : w_rr_lo_idx;
            end else begin
                w_idx = w_fix_idx;
            end
        end
    end

    // Explicit wrap keeps ptr inside 0..WIDTH-1 for non-power-of-2 widths.
    assign w_ptr_nxt = (w_idx == IW'(WIDTH - 1)) ? '0 : w_idx + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if ((MODE == 1) && w_xfer_in && w_any) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_any       <= 1'b0;
            r_multi     <= 1'b0;
        end else if (w_xfer_in) begin
            r_out_valid <= 1'b1;
            r_idx       <= w_idx;
            r_any       <= w_any;
            r_multi     <= w_multi;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign idx       = r_idx;
    assign any       = r_any;
    assign multi     = r_multi;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: a fixed-priority and a round-robin instance share
// stimulus; a scan-based model is checked every cycle, literals pin key points.
module tb_prio_encoder_rr;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] req;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready0, any0, multi0, out_valid0;
    logic [1:0]   idx0;
    logic         in_ready1, any1, multi1, out_valid1;
    logic [1:0]   idx1;

    int checks = 0;
    int errors = 0;

    prio_encoder_rr #(.WIDTH(W), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .in_valid(in_valid),
        .in_ready(in_ready0), .idx(idx0), .any(any0), .multi(multi0),
        .out_valid(out_valid0), .out_ready(out_ready)
    );

    prio_encoder_rr #(.WIDTH(W), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .in_valid(in_valid),
        .in_ready(in_ready1), .idx(idx1), .any(any1), .multi(multi1),
        .out_valid(out_valid1), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state per mode: [0] fixed priority, [1] round robin.
    int m_valid [2];
    int m_idx   [2];
    int m_any   [2];
    int m_multi [2];
    int m_ptr   [2];

    function automatic int pick(input int mode, input logic [W-1:0] r, input int ptr);
        int j;
        if (mode == 0) begin
            for (int k = W - 1; k >= 0; k--) if (r[k]) return k;
        end else begin
            for (int k = 0; k < W; k++) begin
                j = (ptr + k) % W;
                if (r[j]) return j;
            end
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                m_valid[m] = 0; m_idx[m] = 0; m_any[m] = 0; m_multi[m] = 0; m_ptr[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (in_valid && (m_valid[m] == 0 || out_ready)) begin
                    m_valid[m] = 1;
                    m_idx[m]   = pick(m, req, m_ptr[m]);
                    m_any[m]   = (req != 0) ? 1 : 0;
                    m_multi[m] = ($countones(req) >= 2) ? 1 : 0;
                    if (m == 1 && req != 0) m_ptr[m] = (m_idx[m] + 1) % W;
                end else if (out_ready) begin
                    m_valid[m] = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m0_out_valid", int'(out_valid0), m_valid[0]);
        chk("m1_out_valid", int'(out_valid1), m_valid[1]);
        chk("m0_in_ready", int'(in_ready0), (m_valid[0] == 0 || out_ready) ? 1 : 0);
        chk("m1_in_ready", int'(in_ready1), (m_valid[1] == 0 || out_ready) ? 1 : 0);
        if (m_valid[0] != 0) begin
            chk("m0_idx", int'(idx0), m_idx[0]);
            chk("m0_any", int'(any0), m_any[0]);
            chk("m0_multi", int'(multi0), m_multi[0]);
        end
        if (m_valid[1] != 0) begin
            chk("m1_idx", int'(idx1), m_idx[1]);
            chk("m1_any", int'(any1), m_any[1]);
            chk("m1_multi", int'(multi1), m_multi[1]);
        end
    end

    task automatic step(input logic v, input logic [W-1:0] r, input logic ordy);
        in_valid  = v;
        req       = r;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] sweep_req [16] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
                                     4'b0110, 4'b1100, 4'b0101, 4'b1010, 4'b0111, 4'b1110,
                                     4'b1001, 4'b1011, 4'b1101, 4'b1111};
    int sweep_idx [16] = '{0, 0, 1, 2, 3, 1, 2, 3, 2, 3, 2, 3, 3, 3, 3, 3};
    int rot_idx [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; req = '0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid0", int'(out_valid0), 0);
        chk("rst_in_ready1", int'(in_ready1), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fixed-priority sweep, one result per cycle.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, sweep_req[i], 1'b1);
            chk($sformatf("sweep%0d_idx", i), int'(idx0), sweep_idx[i]);
            chk($sformatf("sweep%0d_any", i), int'(any0), (i == 0) ? 0 : 1);
            chk($sformatf("sweep%0d_multi", i), int'(multi0), (i >= 5) ? 1 : 0);
            chk($sformatf("sweep%0d_valid", i), int'(out_valid0), 1);
        end

        step(1'b0, '0, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin rotation and wrap.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b1111, 1'b1);
            chk($sformatf("rot%0d_idx", i), int'(idx1), rot_idx[i]);
        end
        step(1'b1, 4'b1001, 1'b1);
        chk("rr_1001_idx", int'(idx1), 3);
        step(1'b1, 4'b1111, 1'b1);
        chk("rr_ptr0_idx", int'(idx1), 0);

        // Zero vector keeps ptr=2.
        step(1'b1, 4'b0010, 1'b1);
        chk("rr_0010_idx", int'(idx1), 1);
        step(1'b1, 4'b0000, 1'b1);
        chk("rr_zero_any", int'(any1), 0);
        chk("rr_zero_idx", int'(idx1), 0);
        chk("rr_zero_valid", int'(out_valid1), 1);
        step(1'b1, 4'b0101, 1'b1);
        chk("rr_0101_idx", int'(idx1), 2);

        // Backpressure: results hold, ptr frozen, then swap on the release edge.
        step(1'b1, 4'b1111, 1'b1);
        chk("bp_first_idx1", int'(idx1), 3);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b0001, 1'b0);
            chk($sformatf("bp%0d_in_ready", i), int'(in_ready1), 0);
            chk($sformatf("bp%0d_idx1", i), int'(idx1), 3);
            chk($sformatf("bp%0d_idx0", i), int'(idx0), 3);
            chk($sformatf("bp%0d_valid", i), int'(out_valid1), 1);
        end
        step(1'b1, 4'b0011, 1'b1);
        chk("bp_swap_idx1", int'(idx1), 0);
        chk("bp_swap_idx0", int'(idx0), 1);
        chk("bp_swap_valid", int'(out_valid1), 1);

        // Idle cycle with junk req drains and leaves ptr alone.
        step(1'b0, 4'b1111, 1'b1);
        chk("drain_valid", int'(out_valid1), 0);
        step(1'b1, 4'b1111, 1'b1);
        chk("after_idle_idx1", int'(idx1), 1);

        // Reset mid-stream with a pending result and nonzero ptr.
        step(1'b1, 4'b1111, 1'b1);
        chk("pre_rst_idx1", int'(idx1), 2);
        step(1'b0, 4'b0000, 1'b0);
        chk("pre_rst_valid", int'(out_valid1), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid1", int'(out_valid1), 0);
        chk("async_rst_valid0", int'(out_valid0), 0);
        chk("async_rst_idx0", int'(idx0), 0);
        chk("async_rst_in_ready", int'(in_ready1), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 4'b1111, 1'b1);
        chk("post_rst_idx1", int'(idx1), 0);
        chk("post_rst_idx0", int'(idx0), 3);
        step(1'b0, '0, 1'b1);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
